control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Microcode step sequencer for the 8-bit CPU. Tracks the T-state and the current opcode, and produces
//  select/enable fields for the two register 3-8 decoders: one for load strobes, one for bus output
//  enables. It also produces the PC/ALU/flag strobes. Sits between the instruction register and the decoders.
// PARAMETERS
//  MAX_STEPS  5  T-states per instruction (T0..T4); step counter wraps to 0 after T(MAX_STEPS-1)
//  STEP_W     3  width of step counter
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  ena        in   1  1 = advance; 0 = freeze step, all strobes inactive
//  opcode     in   4  IR[7:4], stable from T2 to end of instruction
//  carry_flag in   1  registered ALU carry
//  zero_flag  in   1  registered ALU zero
//  ld_sel     out  3  load-decoder select (register index)
//  ld_g1      out  1  load-decoder G1 (active high)
//  ld_g2      out  2  load-decoder G2 (active low pair)
//  oe_sel     out  3  output-decoder select
//  oe_g1      out  1  output-decoder G1
//  oe_g2      out  2  output-decoder G2
//  pc_inc     out  1  PC increment strobe
//  alu_sub    out  1  ALU subtract select
//  flags_ld   out  1  latch carry/zero
//  step       out  3  current T-state (debug)
//  halted     out  1  sticky halt
// BEHAVIOUR
//  Register index map: 0 PC, 1 MAR, 2 RAM, 3 IR(low nibble), 4 A, 5 B, 6 OUT, 7 ALU (oe only).
//  Decoder drive: active = {g1=1, g2=2'b00, sel=idx}. Inactive = {g1=0, g2=2'b11, sel=3'b000}.
//  Reset (async): step=0, halted=0, run=0. Every output inactive/0 while rst_n=0 and for the first clk after release.
//  run sets on the first clk after reset release. T0 is driven in the next cycle.
//  Outputs are combinational from (run, ena, halted, step, opcode, flags). No extra latency.
//  Step advance on clk when run & ena & ~halted: last active step of opcode -> 0, else step+1.
//  Fetch: T0 oe PC, ld MAR | T1 oe RAM, ld IR, pc_inc.
//  Execute (T2/T3/T4), "end" = step returns to 0 next clk:
//   0 NOP: no T2; end after T1
//   1 LDA: T2 IR->MAR | T3 RAM->A, end
//   2 ADD: T2 IR->MAR | T3 RAM->B | T4 ALU->A, alu_sub=0, flags_ld, end
//   3 SUB: as ADD with alu_sub=1
//   4 STA: T2 IR->MAR | T3 A->RAM, end
//   5 LDI: T2 IR->A, end
//   6 JMP: T2 IR->PC, end
//   7 JC: T2 IR->PC only if carry_flag, else no strobes; end at T2
//   8 JZ: as JC using zero_flag
//   E OUT: T2 A->OUT, end
//   F HLT: T2 no strobes; halted=1 at clk; step frozen, all outputs inactive until reset
//   9-D: decode as NOP
//  ena=0 mid-instruction: step holds and strobes go inactive. The same step resumes when ena=1.
//  Reset mid-instruction aborts immediately; restart at T0 after run sets.
//  Flags sample combinationally in JC/JZ T2. Simultaneous flag change and clk uses the pre-edge value.
// STRUCTURE
//  cpu_ctrl_pkg: opcode localparams, register index localparams, MAX_STEPS, control-word field layout.
//  Sub-module microcode_rom: combinational (step, opcode, flags) -> control word + last_step bit.
//  Top level holds the step counter, run, halted, the gating, and mapping to decoder fields.
// TESTING
//  1 Reset release, ena=1, opcode=1 -> cycle1 all inactive. T0 ld_sel=1 oe_sel=0. T1 ld_sel=3 oe_sel=2 pc_inc.
//    T2 ld 1/oe 3. T3 ld 4/oe 2. Then step=0.
//  2 opcode=3 -> T4 ld_sel=4, oe_sel=7, alu_sub=1, flags_ld=1. Step wraps 4->0.
//  3 opcode=7: carry=0 -> T2 ld_g1=0, step 2->0. carry=1 -> T2 ld_sel=0, oe_sel=3.
//  4 opcode=F -> after T2 halted=1, step stays 2, g1s=0 for 20 clks. rst_n pulse clears halted.
//  5 opcode=2, drop ena at T3 for 3 clks -> step=3 held, strobes inactive. Resume -> T3 then T4.
//  6 Assert rst_n=0 at T3 of ADD -> same-cycle outputs inactive, step=0. Recover with fetch T0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, register indices and control-word layout for the CPU sequencer
package cpu_ctrl_pkg;

  localparam int CPU_MAX_STEPS = 5;
  localparam int CPU_STEP_W    = 3;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam logic [2:0] REG_PC  = 3'd0;
  localparam logic [2:0] REG_MAR = 3'd1;
  localparam logic [2:0] REG_RAM = 3'd2;
  localparam logic [2:0] REG_IR  = 3'd3;
  localparam logic [2:0] REG_A   = 3'd4;
  localparam logic [2:0] REG_B   = 3'd5;
  localparam logic [2:0] REG_OUT = 3'd6;
  localparam logic [2:0] REG_ALU = 3'd7;

  typedef struct packed {
    logic       ld_en;
    logic [2:0] ld_idx;
    logic       oe_en;
    logic [2:0] oe_idx;
    logic       pc_inc;
    logic       alu_sub;
    logic       flags_ld;
    logic       halt;
    logic       last;
  } ctrl_word_t;

  localparam int CW_W = $bits(ctrl_word_t);

  // One bus transfer: src drives the bus, dst latches it.
  function automatic ctrl_word_t xfer(input logic [2:0] src, input logic [2:0] dst);
    ctrl_word_t w;
    w        = '0;
    w.oe_en  = 1'b1;
    w.oe_idx = src;
    w.ld_en  = 1'b1;
    w.ld_idx = dst;
    return w;
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational (step, opcode, flags) to control word decode
module microcode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int STEP_W = CPU_STEP_W
) (
  input  logic [STEP_W-1:0] step,
  input  logic [3:0]        opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [CW_W-1:0]   cw
);

  opcode_e    op;
  ctrl_word_t w;

  assign op = opcode_e'(opcode);
  assign cw = w;

  always_comb begin
    w = '0;
    case (step)
      STEP_W'(0): w = xfer(REG_PC, REG_MAR);
      STEP_W'(1): begin
        w        = xfer(REG_RAM, REG_IR);
        w.pc_inc = 1'b1;
        // Opcodes with no execute phase (NOP and the unused 9-D) end after fetch.
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP,
          OP_JC, OP_JZ, OP_OUT, OP_HLT: w.last = 1'b0;
          default:                      w.last = 1'b1;
        endcase
      end
      STEP_W'(2): begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w = xfer(REG_IR, REG_MAR);
          OP_LDI: begin w = xfer(REG_IR, REG_A);  w.last = 1'b1; end
          OP_JMP: begin w = xfer(REG_IR, REG_PC); w.last = 1'b1; end
          OP_JC: begin
            if (carry_flag) w = xfer(REG_IR, REG_PC);
            w.last = 1'b1;
          end
          OP_JZ: begin
            if (zero_flag) w = xfer(REG_IR, REG_PC);
            w.last = 1'b1;
          end
          OP_OUT: begin w = xfer(REG_A, REG_OUT); w.last = 1'b1; end
          OP_HLT: w.halt = 1'b1;
          default: w.last = 1'b1;
        endcase
      end
      STEP_W'(3): begin
        case (op)
          OP_LDA:         begin w = xfer(REG_RAM, REG_A); w.last = 1'b1; end
          OP_ADD, OP_SUB: w = xfer(REG_RAM, REG_B);
          OP_STA:         begin w = xfer(REG_A, REG_RAM); w.last = 1'b1; end
          default:        w.last = 1'b1;
        endcase
      end
      STEP_W'(4): begin
        if (op == OP_ADD || op == OP_SUB) begin
          w          = xfer(REG_ALU, REG_A);
          w.alu_sub  = (op == OP_SUB);
          w.flags_ld = 1'b1;
        end
        w.last = 1'b1;
      end
      default: w.last = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T-state counter, run/halt state and decoder field drive for the CPU
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_STEPS = CPU_MAX_STEPS,
  parameter int STEP_W    = CPU_STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [3:0]        opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [2:0]        ld_sel,
  output logic              ld_g1,
  output logic [1:0]        ld_g2,
  output logic [2:0]        oe_sel,
  output logic              oe_g1,
  output logic [1:0]        oe_g2,
  output logic              pc_inc,
  output logic              alu_sub,
  output logic              flags_ld,
  output logic [STEP_W-1:0] step,
  output logic              halted
);

  logic [STEP_W-1:0] step_q;
  logic              run_q;
  logic              halted_q;
  logic [CW_W-1:0]   cw_bits;
  ctrl_word_t        cw;
  logic              active;

  microcode_rom #(.STEP_W(STEP_W)) u_rom (
    .step       (step_q),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .cw         (cw_bits)
  );

  assign cw     = ctrl_word_t'(cw_bits);
  assign active = run_q & ena & ~halted_q;

  // run stays low for one clk after reset so the first visible T-state is a clean T0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= '0;
      run_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (active) begin
        if (cw.halt) begin
          halted_q <= 1'b1;
        end else if (cw.last || step_q == STEP_W'(MAX_STEPS - 1)) begin
          step_q <= '0;
        end else begin
          step_q <= step_q + STEP_W'(1);
        end
      end
    end
  end

  assign ld_g1    = active & cw.ld_en;
  assign ld_g2    = {2{~ld_g1}};
  assign ld_sel   = ld_g1 ? cw.ld_idx : 3'b000;
  assign oe_g1    = active & cw.oe_en;
  assign oe_g2    = {2{~oe_g1}};
  assign oe_sel   = oe_g1 ? cw.oe_idx : 3'b000;
  assign pc_inc   = active & cw.pc_inc;
  assign alu_sub  = active & cw.alu_sub;
  assign flags_ld = active & cw.flags_ld;
  assign step     = step_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - table-driven scoreboard bench for control_sequencer
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, ena, carry_flag, zero_flag;
  logic [3:0] opcode;
  logic [2:0] ld_sel, oe_sel, step;
  logic       ld_g1, oe_g1, pc_inc, alu_sub, flags_ld, halted;
  logic [1:0] ld_g2, oe_g2;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .ld_sel(ld_sel), .ld_g1(ld_g1), .ld_g2(ld_g2),
    .oe_sel(oe_sel), .oe_g1(oe_g1), .oe_g2(oe_g2),
    .pc_inc(pc_inc), .alu_sub(alu_sub), .flags_ld(flags_ld),
    .step(step), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic [3:0] op;
    logic       cy, zf;
    logic [7:0] stp;
    logic       ldg;
    logic [7:0] lds;
    logic       oeg;
    logic [7:0] oes;
    logic       pc, sub, fl, hlt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   vec_no = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [3:0] op, input logic cy, input logic zf,
                     input logic [7:0] stp, input logic ldg, input logic [7:0] lds,
                     input logic oeg, input logic [7:0] oes, input logic pc,
                     input logic sub, input logic fl, input logic hlt);
    vec_t v;
    v.ena = en; v.op = op; v.cy = cy; v.zf = zf; v.stp = stp;
    v.ldg = ldg; v.lds = lds; v.oeg = oeg; v.oes = oes;
    v.pc = pc; v.sub = sub; v.fl = fl; v.hlt = hlt;
    tbl.push_back(v);
  endtask

  task automatic add_idle(input logic en, input logic [3:0] op, input logic cy,
                          input logic zf, input logic [7:0] stp, input logic hlt);
    add(en, op, cy, zf, stp, 0, 0, 0, 0, 0, 0, 0, hlt);
  endtask

  task automatic add_x(input logic [3:0] op, input logic cy, input logic zf, input logic [7:0] stp,
                       input logic [7:0] lds, input logic [7:0] oes, input logic pc,
                       input logic sub, input logic fl);
    add(1, op, cy, zf, stp, 1, lds, 1, oes, pc, sub, fl, 0);
  endtask

  task automatic fetch(input logic [3:0] op, input logic cy, input logic zf);
    add_x(op, cy, zf, 0, 1, 0, 0, 0, 0);
    add_x(op, cy, zf, 1, 3, 2, 1, 0, 0);
  endtask

  task automatic compare(input vec_t e, input string tag);
    chk({tag, ".step"},     8'(step),     e.stp);
    chk({tag, ".ld_g1"},    8'(ld_g1),    8'(e.ldg));
    chk({tag, ".ld_g2"},    8'(ld_g2),    e.ldg ? 8'd0 : 8'd3);
    chk({tag, ".ld_sel"},   8'(ld_sel),   e.lds);
    chk({tag, ".oe_g1"},    8'(oe_g1),    8'(e.oeg));
    chk({tag, ".oe_g2"},    8'(oe_g2),    e.oeg ? 8'd0 : 8'd3);
    chk({tag, ".oe_sel"},   8'(oe_sel),   e.oes);
    chk({tag, ".pc_inc"},   8'(pc_inc),   8'(e.pc));
    chk({tag, ".alu_sub"},  8'(alu_sub),  8'(e.sub));
    chk({tag, ".flags_ld"}, 8'(flags_ld), 8'(e.fl));
    chk({tag, ".halted"},   8'(halted),   8'(e.hlt));
  endtask

  task automatic chk_inactive(input string tag);
    vec_t e;
    e.stp = 0; e.ldg = 0; e.lds = 0; e.oeg = 0; e.oes = 0;
    e.pc = 0; e.sub = 0; e.fl = 0; e.hlt = 0;
    e.ena = 0; e.op = 0; e.cy = 0; e.zf = 0;
    compare(e, tag);
  endtask

  // Called at posedge+1: drive one cycle, queue its expectation, check at the falling edge.
  task automatic drive_and_check(input vec_t v);
    ena = v.ena; opcode = v.op; carry_flag = v.cy; zero_flag = v.zf;
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      compare(exp_q.pop_front(), $sformatf("v%0d", vec_no));
    end
    vec_no++;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) begin
      drive_and_check(tbl[i]);
      @(posedge clk); #1;
    end
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_inactive("in_reset");
    rst_n = 1'b1;

    add_idle(1, 4'h1, 0, 0, 0, 0);
    fetch(4'h1, 0, 0);
    add_x(4'h1, 0, 0, 2, 1, 3, 0, 0, 0);
    add_x(4'h1, 0, 0, 3, 4, 2, 0, 0, 0);
    fetch(4'h3, 0, 0);
    add_x(4'h3, 0, 0, 2, 1, 3, 0, 0, 0);
    add_x(4'h3, 0, 0, 3, 5, 2, 0, 0, 0);
    add_x(4'h3, 0, 0, 4, 4, 7, 0, 1, 1);
    fetch(4'h7, 0, 0);
    add_idle(1, 4'h7, 0, 0, 2, 0);
    fetch(4'h7, 1, 0);
    add_x(4'h7, 1, 0, 2, 0, 3, 0, 0, 0);
    fetch(4'h8, 0, 1);
    add_x(4'h8, 0, 1, 2, 0, 3, 0, 0, 0);
    fetch(4'h8, 1, 0);
    add_idle(1, 4'h8, 1, 0, 2, 0);
    fetch(4'h5, 0, 0);
    add_x(4'h5, 0, 0, 2, 4, 3, 0, 0, 0);
    fetch(4'h0, 0, 0);
    fetch(4'h4, 0, 0);
    add_x(4'h4, 0, 0, 2, 1, 3, 0, 0, 0);
    add_x(4'h4, 0, 0, 3, 2, 4, 0, 0, 0);
    fetch(4'hE, 0, 0);
    add_x(4'hE, 0, 0, 2, 6, 4, 0, 0, 0);
    fetch(4'hA, 0, 0);
    fetch(4'h2, 0, 0);
    add_x(4'h2, 0, 0, 2, 1, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) add_idle(0, 4'h2, 0, 0, 3, 0);
    add_x(4'h2, 0, 0, 3, 5, 2, 0, 0, 0);
    add_x(4'h2, 0, 0, 4, 4, 7, 0, 0, 1);
    fetch(4'hF, 0, 0);
    add_idle(1, 4'hF, 0, 0, 2, 0);
    for (int i = 0; i < 20; i++) add_idle(1, 4'hF, 0, 0, 2, 1);
    run_tbl();

    rst_n = 1'b0;
    #1;
    chk_inactive("halt_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    add_idle(1, 4'h2, 0, 0, 0, 0);
    fetch(4'h2, 0, 0);
    add_x(4'h2, 0, 0, 2, 1, 3, 0, 0, 0);
    run_tbl();
    add_x(4'h2, 0, 0, 3, 5, 2, 0, 0, 0);
    drive_and_check(tbl.pop_front());
    #2 rst_n = 1'b0;
    #1;
    chk_inactive("t3_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    add_idle(1, 4'h2, 0, 0, 0, 0);
    fetch(4'h2, 0, 0);
    run_tbl();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
